// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencing controller.
package mc_pkg;

   typedef enum logic [3:0] {
      S_IF     = 4'd0,
      S_ID     = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXE    = 4'd6,
      S_RWB    = 4'd7,
      S_BR     = 4'd8,
      S_JMP    = 4'd9,
      S_IEXE   = 4'd10,
      S_IWB    = 4'd11,
      S_HALT   = 4'd12
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_LOGI  = 2'b11;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_SEXT    = 2'b10;
   localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // andi/ori zero-extend their immediate; everything else sign-extends
   function automatic logic is_logic_imm(input logic [5:0] op);
      return (op == OP_ANDI) || (op == OP_ORI);
   endfunction

endpackage

// File: rtl/mc_retire_counter.sv
// Retired-instruction counter; wraps modulo 2^CNT_W, cleared by async reset.
module mc_retire_counter
   import mc_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_count <= '0;
      else if (i_inc)
         r_count <= r_count + 1'b1;
   end

   assign o_count = r_count;

endmodule

// File: rtl/mc_control.sv
// Multi-cycle sequencing controller: state register, Moore output decode and
// retirement tracking for the shared-ALU / unified-memory MIPS datapath.
//
// state  | meaning
// IF     | fetch at PC, PC+4; waits for mem_ready
// ID     | decode, branch target into ALUOut
// MEMADR | lw/sw address = A + SignExt
// MEMRD  | load read; waits for mem_ready
// MEMWB  | load writeback from MDR to rt
// MEMWR  | store write; waits for mem_ready
// EXE    | R-type ALU op
// RWB    | R-type writeback to rd
// BR     | beq/bne compare and conditional PC load
// JMP    | jump
// IEXE   | addi/andi/ori ALU op
// IWB    | immediate writeback to rt
// HALT   | undefined opcode trap; left only via reset
module mc_control
   import mc_pkg::*;
#(
   parameter int CNT_W        = 32,
   parameter bit ILLEGAL_HALT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             branch_ne,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic             sign,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   state_t r_state;
   state_t w_next;
   logic   w_retire;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IF:     w_next = mem_ready ? S_ID : S_IF;
         S_ID: begin
            case (opcode)
               OP_R:                      w_next = S_EXE;
               OP_LW, OP_SW:              w_next = S_MEMADR;
               OP_BEQ, OP_BNE:            w_next = S_BR;
               OP_J:                      w_next = S_JMP;
               OP_ADDI, OP_ANDI, OP_ORI:  w_next = S_IEXE;
               default:                   w_next = ILLEGAL_HALT ? S_HALT : S_IF;
            endcase
         end
         S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  w_next = S_IF;
         S_MEMWR:  w_next = mem_ready ? S_IF : S_MEMWR;
         S_EXE:    w_next = S_RWB;
         S_RWB:    w_next = S_IF;
         S_BR:     w_next = S_IF;
         S_JMP:    w_next = S_IF;
         S_IEXE:   w_next = S_IWB;
         S_IWB:    w_next = S_IF;
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_IF;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= S_IF;
      else
         r_state <= w_next;
   end

   // Every path back into IF from another state completes an instruction
   assign w_retire = (w_next == S_IF) && (r_state != S_IF);

   mc_retire_counter #(.CNT_W(CNT_W)) u_retire (
      .clk     (clk),
      .rst_n   (rst),
      .i_inc   (w_retire),
      .o_count (instr_count)
   );

   // Decode is combinational so the IF strobes can follow mem_ready in-cycle
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_B;
      alu_op        = ALU_ADD;
      pc_source     = PCSRC_ALU;
      sign          = 1'b0;
      halted        = 1'b0;
      if (rst) begin
         sign = !is_logic_imm(opcode);
         case (r_state)
            S_IF: begin
               mem_read  = 1'b1;
               alu_src_b = SRCB_FOUR;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            S_ID:     alu_src_b = SRCB_SEXT_SH;
            S_MEMADR: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_SEXT;
            end
            S_MEMRD: begin
               mem_read = 1'b1;
               iord     = 1'b1;
            end
            S_MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
               mem_write = 1'b1;
               iord      = 1'b1;
            end
            S_EXE: begin
               alu_src_a = 1'b1;
               alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            S_BR: begin
               alu_src_a     = 1'b1;
               alu_op        = ALU_SUB;
               pc_write_cond = 1'b1;
               pc_source     = PCSRC_ALUOUT;
               branch_ne     = (opcode == OP_BNE);
            end
            S_JMP: begin
               pc_write  = 1'b1;
               pc_source = PCSRC_JUMP;
            end
            S_IEXE: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_SEXT;
               alu_op    = is_logic_imm(opcode) ? ALU_LOGI : ALU_ADD;
            end
            S_IWB:    reg_write = 1'b1;
            S_HALT:   halted = 1'b1;
            default:  halted = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: the driver pushes one expected output
// vector per cycle, a negedge monitor pops and compares against the DUT.
module tb_mc_control;

   typedef enum int {E_RST, E_IF, E_ID, E_MEMADR, E_MEMRD, E_MEMWB, E_MEMWR,
                     E_EXE, E_RWB, E_BR, E_JMP, E_IEXE, E_IWB, E_HALT} e_t;

   typedef struct {
      int          dut;
      e_t          st;
      int          cyc;
      logic [18:0] vec;
      int          cnt;
   } exp_t;

   logic clk;
   logic rst_a, rst_b;
   logic [5:0] op_a, op_b;
   logic mr_a, mr_b;

   logic pcw_a, pcc_a, bne_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, rd_a, rw_a, sa_a, sg_a, hl_a;
   logic [1:0] sb_a, ao_a, ps_a;
   logic [31:0] cnt_out_a;
   logic pcw_b, pcc_b, bne_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, rd_b, rw_b, sa_b, sg_b, hl_b;
   logic [1:0] sb_b, ao_b, ps_b;
   logic [2:0] cnt_out_b;

   mc_control #(.CNT_W(32), .ILLEGAL_HALT(1'b1)) dut_a (
      .clk(clk), .rst(rst_a), .opcode(op_a), .mem_ready(mr_a),
      .pc_write(pcw_a), .pc_write_cond(pcc_a), .branch_ne(bne_a), .iord(iord_a),
      .mem_read(mrd_a), .mem_write(mwr_a), .ir_write(irw_a), .mem_to_reg(m2r_a),
      .reg_dst(rd_a), .reg_write(rw_a), .alu_src_a(sa_a), .alu_src_b(sb_a),
      .alu_op(ao_a), .pc_source(ps_a), .sign(sg_a), .halted(hl_a),
      .instr_count(cnt_out_a));

   mc_control #(.CNT_W(3), .ILLEGAL_HALT(1'b0)) dut_b (
      .clk(clk), .rst(rst_b), .opcode(op_b), .mem_ready(mr_b),
      .pc_write(pcw_b), .pc_write_cond(pcc_b), .branch_ne(bne_b), .iord(iord_b),
      .mem_read(mrd_b), .mem_write(mwr_b), .ir_write(irw_b), .mem_to_reg(m2r_b),
      .reg_dst(rd_b), .reg_write(rw_b), .alu_src_a(sa_b), .alu_src_b(sb_b),
      .alu_op(ao_b), .pc_source(ps_b), .sign(sg_b), .halted(hl_b),
      .instr_count(cnt_out_b));

   logic [18:0] vec_a, vec_b;
   assign vec_a = {pcw_a, pcc_a, bne_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, rd_a, rw_a,
                   sa_a, sb_a, ao_a, ps_a, sg_a, hl_a};
   assign vec_b = {pcw_b, pcc_b, bne_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, rd_b, rw_b,
                   sa_b, sb_b, ao_b, ps_b, sg_b, hl_b};

   localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                          BNE = 6'b000101, J = 6'b000010, ADDI = 6'b001000,
                          ANDI = 6'b001100, ORI = 6'b001101, BAD = 6'b111111;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   cnt_a = 0;
   int   cnt_b = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic string st_name(input e_t s);
      case (s)
         E_RST: return "RST";       E_IF: return "IF";       E_ID: return "ID";
         E_MEMADR: return "MEMADR"; E_MEMRD: return "MEMRD"; E_MEMWB: return "MEMWB";
         E_MEMWR: return "MEMWR";   E_EXE: return "EXE";     E_RWB: return "RWB";
         E_BR: return "BR";         E_JMP: return "JMP";     E_IEXE: return "IEXE";
         E_IWB: return "IWB";       default: return "HALT";
      endcase
   endfunction

   // Expected outputs straight from the state/output table
   function automatic logic [18:0] exp_vec(input e_t st, input logic [5:0] op, input bit mr);
      logic pcw, pcc, bne, io, rdm, wrm, irw, m2r, rdst, rw, sa, sg, hl;
      logic [1:0] sbv, ao, ps;
      {pcw, pcc, bne, io, rdm, wrm, irw, m2r, rdst, rw, sa, sg, hl} = '0;
      sbv = 2'b00; ao = 2'b00; ps = 2'b00;
      if (st == E_RST) return '0;
      sg = !(op == ANDI || op == ORI);
      case (st)
         E_IF:     begin rdm = 1; sbv = 2'b01; irw = mr; pcw = mr; end
         E_ID:     sbv = 2'b11;
         E_MEMADR: begin sa = 1; sbv = 2'b10; end
         E_MEMRD:  begin rdm = 1; io = 1; end
         E_MEMWB:  begin rw = 1; m2r = 1; end
         E_MEMWR:  begin wrm = 1; io = 1; end
         E_EXE:    begin sa = 1; ao = 2'b10; end
         E_RWB:    begin rw = 1; rdst = 1; end
         E_BR:     begin sa = 1; ao = 2'b01; pcc = 1; ps = 2'b01; bne = (op == BNE); end
         E_JMP:    begin pcw = 1; ps = 2'b10; end
         E_IEXE:   begin sa = 1; sbv = 2'b10; ao = (op == ADDI) ? 2'b00 : 2'b11; end
         E_IWB:    rw = 1;
         E_HALT:   hl = 1;
         default:  hl = 0;
      endcase
      return {pcw, pcc, bne, io, rdm, wrm, irw, m2r, rdst, rw, sa, sbv, ao, ps, sg, hl};
   endfunction

   // Called just after a rising edge: drive inputs for this cycle, queue expectation
   task automatic step(input int dut, input e_t st, input logic [5:0] op, input bit mr);
      exp_t e;
      if (dut == 0) begin op_a = op; mr_a = mr; end
      else          begin op_b = op; mr_b = mr; end
      e.dut = dut; e.st = st; e.cyc = cyc;
      e.vec = exp_vec(st, op, mr);
      e.cnt = (dut == 0) ? cnt_a : cnt_b;
      sb.push_back(e);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input int dut, input logic [5:0] op, input int waits);
      repeat (waits) step(dut, E_IF, op, 1'b0);
      step(dut, E_IF, op, 1'b1);
      step(dut, E_ID, op, 1'b0);
   endtask

   task automatic retire(input int dut);
      if (dut == 0) cnt_a++;
      else          cnt_b = (cnt_b + 1) % 8;
   endtask

   task automatic r_type(input int dut);
      fetch(dut, R, 0);
      step(dut, E_EXE, R, 1'b0);
      step(dut, E_RWB, R, 1'b1);
      retire(dut);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic [18:0] av;
         int ac;
         e  = sb.pop_front();
         av = (e.dut == 0) ? vec_a : vec_b;
         ac = (e.dut == 0) ? int'(cnt_out_a) : int'(cnt_out_b);
         checks++;
         if (av !== e.vec || ac != e.cnt) begin
            errors++;
            $display("FAIL %s dut%0d cyc%0d: got outputs %b count %0d, expected outputs %b count %0d",
                     st_name(e.st), e.dut, e.cyc, av, ac, e.vec, e.cnt);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
      $fatal(1);
   end

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      op_a = R; op_b = R; mr_a = 1'b1; mr_b = 1'b1;
      #1;
      rst_a = 1'b0; rst_b = 1'b0;
      @(posedge clk); #1;

      // Reset with IF-enabling inputs: everything held at 0
      repeat (3) step(0, E_RST, R, 1'b1);
      rst_a = 1'b1;
      r_type(0);

      // lw with two memory wait cycles; mem_ready low in ID is ignored
      fetch(0, LW, 0);
      step(0, E_MEMADR, LW, 1'b1);
      step(0, E_MEMRD, LW, 1'b0);
      step(0, E_MEMRD, LW, 1'b0);
      step(0, E_MEMRD, LW, 1'b1);
      step(0, E_MEMWB, LW, 1'b0);
      retire(0);

      // sw with three fetch wait cycles and one store wait cycle
      fetch(0, SW, 3);
      step(0, E_MEMADR, SW, 1'b0);
      step(0, E_MEMWR, SW, 1'b0);
      step(0, E_MEMWR, SW, 1'b1);
      retire(0);

      // bne then beq
      fetch(0, BNE, 0); step(0, E_BR, BNE, 1'b1); retire(0);
      fetch(0, BEQ, 0); step(0, E_BR, BEQ, 1'b0); retire(0);

      // jump, immediates
      fetch(0, J, 0); step(0, E_JMP, J, 1'b1); retire(0);
      fetch(0, ANDI, 0); step(0, E_IEXE, ANDI, 1'b0); step(0, E_IWB, ANDI, 1'b0); retire(0);
      fetch(0, ADDI, 0); step(0, E_IEXE, ADDI, 1'b0); step(0, E_IWB, ADDI, 1'b1); retire(0);
      fetch(0, ORI, 1); step(0, E_IEXE, ORI, 1'b1); step(0, E_IWB, ORI, 1'b0); retire(0);

      // Undefined opcode traps; count frozen, mem_ready toggling ignored
      fetch(0, BAD, 0);
      for (int i = 0; i < 10; i++) step(0, E_HALT, BAD, i[0]);

      rst_a = 1'b0;
      cnt_a = 0;
      repeat (2) step(0, E_RST, R, 1'b1);
      rst_a = 1'b1;
      r_type(0);

      // ILLEGAL_HALT=0, 3-bit counter: undefined opcode is a 2-cycle NOP, then wrap
      rst_b = 1'b1;
      fetch(1, BAD, 0);
      retire(1);
      for (int i = 0; i < 7; i++) r_type(1);
      step(1, E_IF, R, 1'b0);

      for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
